sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO: the next generation of the team's 8-bit, 16-entry synchronous FIFO. It adds configurable data width, depth and mode; true full-depth occupancy; simultaneous read/write; programmable almost-full and almost-empty flags; an occupancy count; and sticky overflow/underflow error flags. It sits between producer and consumer blocks on the same clock, connected through the team's FIFO interface and modports.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 46 ++++
 rtl/sync_fifo_param.sv | 117 +++++++++++
 tb/tb_sync_fifo_param.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// pointer/count width helpers, read-mode constants and the error-flag record.
package fifo_pkg;

  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write port, read port that is
// either combinational (first-word-fall-through) or registered with a load enable.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter bit FWFT   = FWFT_OFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  if (FWFT == FWFT_ON) begin : g_async_rd
    assign rd_data = mem_q[rd_addr];
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO control: wrap-bit pointers, occupancy count,
// threshold flags and sticky overflow/underflow, around a fifo_ram instance.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = FWFT_OFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_err_t        err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rd_data;

  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_acc);
    count_d    = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clr_err keeps the flag set.
    err_d.overflow  = (err_q.overflow  && !clr_err) || (wr_en && full);
    err_d.underflow = (err_q.underflow && !clr_err) || (rd_en && empty);
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FWFT   (FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // In fall-through mode the head is masked while empty so reset reads back zero.
  assign rd_data      = (FWFT == FWFT_ON) ? (empty ? '0 : ram_rd_data) : ram_rd_data;
  assign rd_valid     = (FWFT == FWFT_ON) ? !empty : rd_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: a registered-read instance and
// a first-word-fall-through instance sharing clock and reset.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_cmp = 0;
  int n_mis = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (count !== 5'd0) begin
      n_mis++; $display("[TB] FAIL reset_count: got %0d expected 0", count);
    end
    n_cmp++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow, rd_valid} !== 7'b1010000) begin
      n_mis++;
      $display("[TB] FAIL reset_flags: got %b expected 1010000",
               {empty, full, almost_empty, almost_full, overflow, underflow, rd_valid});
    end
    n_cmp++;
    if (rd_data !== 8'h00) begin
      n_mis++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data);
    end
  endtask

  task automatic test_fill;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      tick;
      n_cmp++;
      if (count !== 5'(i + 1) || full !== 1'(i == 15)) begin
        n_mis++;
        $display("[TB] FAIL fill_%0d: got count=%0d full=%b expected count=%0d full=%b",
                 i, count, full, i + 1, (i == 15));
      end
    end
    wr_data = 8'hAA;
    tick;
    wr_en = 0;
    n_cmp++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_mis++;
      $display("[TB] FAIL fill_overflow: got ovf=%b count=%0d expected ovf=1 count=16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      tick;
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 5'(15 - i) || empty !== 1'(i == 15)) begin
        n_mis++;
        $display("[TB] FAIL drain_%0d: got v=%b d=%h cnt=%0d e=%b expected v=1 d=%h cnt=%0d e=%b",
                 i, rd_valid, rd_data, count, empty, 8'(i), 15 - i, (i == 15));
      end
    end
    rd_en = 0;
    tick;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h0F || underflow !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL drain_idle: got v=%b d=%h unf=%b expected v=0 d=0f unf=0",
               rd_valid, rd_data, underflow);
    end
  endtask

  task automatic test_wrap;
    int n;
    logic [7:0] base;
    do_reset;
    for (int r = 0; r < 2; r++) begin
      n    = (r == 0) ? 10 : 12;
      base = (r == 0) ? 8'h10 : 8'h40;
      for (int i = 0; i < n; i++) begin
        wr_en = 1; wr_data = base + 8'(i);
        tick;
      end
      wr_en = 0;
      for (int i = 0; i < n; i++) begin
        rd_en = 1;
        tick;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== base + 8'(i)) begin
          n_mis++;
          $display("[TB] FAIL wrap_r%0d_%0d: got v=%b d=%h expected v=1 d=%h",
                   r, i, rd_valid, rd_data, base + 8'(i));
        end
      end
      rd_en = 0;
    end
    n_cmp++;
    if ({empty, overflow, underflow} !== 3'b100 || count !== 5'd0) begin
      n_mis++;
      $display("[TB] FAIL wrap_end: got e/o/u=%b cnt=%0d expected 100 cnt=0",
               {empty, overflow, underflow}, count);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'h80 + 8'(i);
      tick;
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1; rd_en = 1; wr_data = 8'hA0 + 8'(i);
      tick;
      exp_d = (i < 5) ? 8'h80 + 8'(i) : 8'hA0 + 8'(i - 5);
      n_cmp++;
      if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== exp_d) begin
        n_mis++;
        $display("[TB] FAIL b2b_%0d: got cnt=%0d v=%b d=%h expected cnt=5 v=1 d=%h",
                 i, count, rd_valid, rd_data, exp_d);
      end
    end
    rd_en = 0;
    for (int i = 0; i < 11; i++) begin
      wr_data = 8'hC0 + 8'(i);
      tick;
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_mis++; $display("[TB] FAIL b2b_full: got full=%b cnt=%0d expected 1 16", full, count);
    end
    rd_en = 1; wr_data = 8'hEE;
    tick;
    wr_en = 0; rd_en = 0;
    n_cmp++;
    if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0 || rd_data !== 8'hAF) begin
      n_mis++;
      $display("[TB] FAIL b2b_at_full: got cnt=%0d ovf=%b full=%b d=%h expected 15 1 0 af",
               count, overflow, full, rd_data);
    end
  endtask

  task automatic test_thresholds;
    do_reset;
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1; wr_data = 8'(k);
      tick;
      n_cmp++;
      if ({almost_empty, almost_full} !== {1'(k <= 2), 1'(k >= 14)}) begin
        n_mis++;
        $display("[TB] FAIL thr_up_%0d: got ae/af=%b%b expected %b%b",
                 k, almost_empty, almost_full, (k <= 2), (k >= 14));
      end
    end
    wr_en = 0;
    for (int k = 15; k >= 0; k--) begin
      rd_en = 1;
      tick;
      n_cmp++;
      if ({almost_empty, almost_full} !== {1'(k <= 2), 1'(k >= 14)}) begin
        n_mis++;
        $display("[TB] FAIL thr_dn_%0d: got ae/af=%b%b expected %b%b",
                 k, almost_empty, almost_full, (k <= 2), (k >= 14));
      end
    end
    rd_en = 0;
  endtask

  task automatic test_errors;
    do_reset;
    rd_en = 1;
    tick;
    rd_en = 0;
    n_cmp++;
    if (underflow !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL err_underflow: got unf=%b cnt=%0d v=%b expected 1 0 0", underflow, count, rd_valid);
    end
    wr_en = 1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i);
      tick;
    end
    wr_en = 0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b11) begin
      n_mis++; $display("[TB] FAIL err_both_set: got %b expected 11", {overflow, underflow});
    end
    clr_err = 1;
    tick;
    clr_err = 0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b00) begin
      n_mis++; $display("[TB] FAIL err_clear: got %b expected 00", {overflow, underflow});
    end
    wr_en = 1; clr_err = 1;
    tick;
    wr_en = 0; clr_err = 0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b10 || count !== 5'd16) begin
      n_mis++;
      $display("[TB] FAIL err_set_wins: got o/u=%b cnt=%0d expected 10 16", {overflow, underflow}, count);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = 8'h50 + 8'(i);
      tick;
    end
    wr_en = 0; rd_en = 1;
    tick;
    rd_en = 0;
    n_cmp++;
    if (count !== 5'd7 || rd_data !== 8'h50) begin
      n_mis++; $display("[TB] FAIL arst_pre: got cnt=%0d d=%h expected 7 50", count, rd_data);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (count !== 5'd0 || rd_data !== 8'h00 ||
        {empty, full, almost_empty, almost_full, rd_valid} !== 5'b10100) begin
      n_mis++;
      $display("[TB] FAIL arst_clear: got cnt=%0d d=%h flags=%b expected 0 00 10100",
               count, rd_data, {empty, full, almost_empty, almost_full, rd_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1; wr_data = 8'h77;
    tick;
    wr_en = 0; rd_en = 1;
    tick;
    rd_en = 0;
    n_cmp++;
    if (rd_data !== 8'h77 || count !== 5'd0 || empty !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL arst_after: got d=%h cnt=%0d e=%b expected 77 0 1", rd_data, count, empty);
    end
  endtask

  task automatic test_fwft;
    do_reset;
    f_wr_en = 1; f_wr_data = 8'h00;
    tick;
    n_cmp++;
    if (f_rd_data !== 8'h00 || f_rd_valid !== 1'b1 || f_empty !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL fwft_first: got d=%h v=%b e=%b expected 00 1 0", f_rd_data, f_rd_valid, f_empty);
    end
    for (int i = 1; i < 16; i++) begin
      f_wr_data = 8'(i);
      tick;
    end
    f_wr_en = 0;
    n_cmp++;
    if (f_count !== 5'd16 || f_full !== 1'b1 || f_rd_data !== 8'h00) begin
      n_mis++;
      $display("[TB] FAIL fwft_full: got cnt=%0d full=%b d=%h expected 16 1 00", f_count, f_full, f_rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (f_rd_valid !== 1'b1 || f_rd_data !== 8'(i)) begin
        n_mis++;
        $display("[TB] FAIL fwft_head_%0d: got v=%b d=%h expected v=1 d=%h", i, f_rd_valid, f_rd_data, 8'(i));
      end
      f_rd_en = 1;
      tick;
    end
    f_rd_en = 0;
    n_cmp++;
    if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_underflow !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL fwft_end: got e=%b v=%b unf=%b expected 1 0 0", f_empty, f_rd_valid, f_underflow);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_back_to_back;
    test_thresholds;
    test_errors;
    test_async_reset;
    test_fwft;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
